// File: rtl/i2c_target_model.sv
// I2C target with an auto-incrementing register file, used to close the loop behind an I2C master.
// Bus pins are oversampled on PCLK; sda is open-drain (drives 0 or z only).
module i2c_target_model #(
    parameter logic [6:0]  TARGET_ADDR = 7'h3C,
    parameter int unsigned REG_DEPTH   = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         scl,
    inout  wire                          sda,
    output logic                         busy,
    output logic                         addr_hit,
    output logic                         wr_strobe,
    output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
    output logic [7:0]                   wr_data
);
    localparam int unsigned PW = $clog2(REG_DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    scl_q, sda_q;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [PW-1:0] ptr, ptr_n, wr_addr_n;
    logic [7:0]    wr_data_n;
    logic          phase, phase_n, oe, oe_n, busy_n, addr_hit_n, wr_strobe_n;
    logic [7:0]    regs [REG_DEPTH];

    logic          scl_s_c, sda_s_c, scl_rise_c, scl_fall_c, start_c, stop_c;
    logic          byte_done_c, reg_we_c;
    logic [7:0]    rx_byte_c, rd_byte_c, nxt_byte_c;
    logic [PW-1:0] ptr_inc_c;

    assign sda = oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers (bits 0,1) plus one delay flop (bit 2) for edge detection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_s_c     = scl_q[1];
    assign sda_s_c     = sda_q[1];
    assign scl_rise_c  = scl_q[1] & ~scl_q[2];
    assign scl_fall_c  = ~scl_q[1] & scl_q[2];
    assign start_c     = scl_s_c & sda_q[2] & ~sda_s_c;
    assign stop_c      = scl_s_c & ~sda_q[2] & sda_s_c;
    assign rx_byte_c   = {shift[6:0], sda_s_c};
    assign byte_done_c = scl_rise_c && (bit_cnt == 4'd7);
    assign ptr_inc_c   = ptr + PW'(1);
    assign rd_byte_c   = regs[ptr];
    assign nxt_byte_c  = regs[ptr_inc_c];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            ptr       <= '0;
            phase     <= 1'b0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            ptr       <= ptr_n;
            phase     <= phase_n;
            oe        <= oe_n;
            busy      <= busy_n;
            addr_hit  <= addr_hit_n;
            wr_strobe <= wr_strobe_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs <= '{default: 8'h00};
        end else if (reg_we_c) begin
            regs[ptr] <= rx_byte_c;
        end
    end

    // phase marks the second half of an ACK slot: 0 = waiting to drive, 1 = driving/acked
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        ptr_n       = ptr;
        phase_n     = phase;
        oe_n        = oe;
        busy_n      = busy;
        addr_hit_n  = 1'b0;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        reg_we_c    = 1'b0;

        if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            phase_n   = 1'b0;
            oe_n      = 1'b0;
        end else if (stop_c) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            phase_n   = 1'b0;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
        end else begin
            if (scl_rise_c && (state == ADDR || state == PTR || state == WDATA)) begin
                shift_n   = rx_byte_c;
                bit_cnt_n = bit_cnt + 4'd1;
            end
            case (state)
                ADDR: if (byte_done_c) begin
                    if (rx_byte_c[7:1] == TARGET_ADDR) begin
                        addr_hit_n = 1'b1;
                        busy_n     = 1'b1;
                        state_n    = ADDR_ACK;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IGNORE;
                    end
                end
                PTR: if (byte_done_c) begin
                    ptr_n   = rx_byte_c[PW-1:0];
                    state_n = PTR_ACK;
                end
                WDATA: if (byte_done_c) begin
                    reg_we_c    = 1'b1;
                    wr_strobe_n = 1'b1;
                    wr_addr_n   = ptr;
                    wr_data_n   = rx_byte_c;
                    ptr_n       = ptr_inc_c;
                    state_n     = WDATA_ACK;
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall_c) begin
                    bit_cnt_n = 4'd0;
                    if (!phase) begin
                        oe_n    = 1'b1;
                        phase_n = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        phase_n = 1'b0;
                        if (state == ADDR_ACK && shift[0]) begin
                            shift_n = rd_byte_c;
                            oe_n    = ~rd_byte_c[7];
                            state_n = RDATA;
                        end else if (state == ADDR_ACK) begin
                            state_n = PTR;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise_c) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall_c) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n      = 1'b0;
                            bit_cnt_n = 4'd0;
                            phase_n   = 1'b0;
                            state_n   = RDATA_ACK;
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_s_c) state_n = IGNORE;
                        else         phase_n = 1'b1;
                    end else if (scl_fall_c && phase) begin
                        phase_n = 1'b0;
                        ptr_n   = ptr_inc_c;
                        shift_n = nxt_byte_c;
                        oe_n    = ~nxt_byte_c[7];
                        state_n = RDATA;
                    end
                end
                IDLE, IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: bit-banged I2C master, register model and write/read scoreboards.
module tb_i2c_target_model;
    localparam int unsigned PW = 3;
    localparam int T = 100;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          m_scl = 1'b1;
    logic          m_sda = 1'b1;
    wire           sda;
    logic          busy, addr_hit, wr_strobe;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    i2c_target_model #(.TARGET_ADDR(7'h3C), .REG_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .scl(m_scl), .sda(sda),
        .busy(busy), .addr_hit(addr_hit), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 PCLK = ~PCLK;

    int            checks = 0, failures = 0;
    int            exp_hits = 0, exp_wr = 0, hit_cycles = 0, wr_cycles = 0, dut_drive = 0;
    logic          quiet = 1'b0;
    logic [7:0]    mdl_regs [8];
    logic [PW-1:0] mdl_ptr = '0;
    logic [PW+7:0] sb_wr [$];
    logic [7:0]    sb_rd [$];
    logic [PW+7:0] wr_exp;
    logic          b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Commit monitor: every strobe cycle pops one expected (addr, data) pair
    always @(negedge PCLK) begin
        if (addr_hit) hit_cycles++;
        if (quiet && m_sda && sda === 1'b0) dut_drive++;
        if (wr_strobe) begin
            wr_cycles++;
            if (sb_wr.size() == 0) begin
                check("wr_unexpected", 32'(wr_strobe), 32'd0);
            end else begin
                wr_exp = sb_wr.pop_front();
                check("wr_commit", 32'({wr_addr, wr_data}), 32'(wr_exp));
            end
        end
    end

    task automatic bus_start();
        m_sda = 1'b1; #T; m_scl = 1'b1; #T; m_sda = 1'b0; #T; m_scl = 1'b0; #T;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #T; m_scl = 1'b1; #T; m_sda = 1'b1; #T;
    endtask

    task automatic put_bit(input logic v);
        m_sda = v; #T; m_scl = 1'b1; #(2*T); m_scl = 1'b0; #T;
    endtask

    task automatic get_bit(output logic v);
        m_sda = 1'b1; #T; m_scl = 1'b1; #T; v = sda; #T; m_scl = 1'b0; #T;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(v);
        ack = ~v;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            get_bit(v);
            d[i] = v;
        end
        put_bit(~ack);
    endtask

    task automatic send_addr(input logic [7:0] a);
        logic ack, exp_ack;
        exp_ack = (a[7:1] == 7'h3C);
        if (exp_ack) exp_hits++;
        send_byte(a, ack);
        check("addr_ack", 32'(ack), 32'(exp_ack));
    endtask

    task automatic send_ptr(input logic [7:0] p);
        logic ack;
        send_byte(p, ack);
        mdl_ptr = p[PW-1:0];
        check("ptr_ack", 32'(ack), 32'd1);
    endtask

    task automatic send_data(input logic [7:0] d);
        logic ack;
        sb_wr.push_back({mdl_ptr, d});
        exp_wr++;
        mdl_regs[mdl_ptr] = d;
        mdl_ptr = mdl_ptr + PW'(1);
        send_byte(d, ack);
        check("data_ack", 32'(ack), 32'd1);
    endtask

    task automatic recv_data(input logic ack);
        logic [7:0] d;
        sb_rd.push_back(mdl_regs[mdl_ptr]);
        recv_byte(ack, d);
        check("rd_data", 32'(d), 32'(sb_rd.pop_front()));
        if (ack) mdl_ptr = mdl_ptr + PW'(1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
        #53;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        PRESETn = 1'b1;
        #T;

        // Basic write with two data bytes
        bus_start; send_addr(8'h78); send_ptr(8'h02); send_data(8'hA5); send_data(8'h5A);
        check("busy_mid", 32'(busy), 32'd1);
        bus_stop; #T;
        check("busy_after_stop", 32'(busy), 32'd0);

        // Pointer wrap from 7 to 0, then read back across the wrap
        bus_start; send_addr(8'h78); send_ptr(8'h07); send_data(8'h11); send_data(8'h22); bus_stop;
        bus_start; send_addr(8'h78); send_ptr(8'h07);
        bus_start; send_addr(8'h79); recv_data(1'b1); recv_data(1'b0); bus_stop;

        // Foreign address: no ACK, no drive, no activity
        quiet = 1'b1;
        bus_start; send_addr(8'h52);
        check("busy_foreign", 32'(busy), 32'd0);
        bus_stop; #T;
        quiet = 1'b0;
        check("no_drive_foreign", 32'(dut_drive), 32'd0);

        // Repeated-START read of three bytes ending in NACK
        bus_start; send_addr(8'h78); send_ptr(8'h04); send_data(8'hC3); send_data(8'h3C); bus_stop;
        bus_start; send_addr(8'h78); send_ptr(8'h03);
        bus_start; send_addr(8'h79); recv_data(1'b1); recv_data(1'b1); recv_data(1'b0);
        check("sda_released_nack", 32'(sda), 32'd1);
        bus_stop; #T;
        check("busy_after_read", 32'(busy), 32'd0);

        // Reset while the target is driving a read bit
        bus_start; send_addr(8'h78); send_ptr(8'h00);
        bus_start; send_addr(8'h79);
        get_bit(b);
        check("rd_bit7", 32'(b), 32'(mdl_regs[0][7]));
        check("drive_before_rst", 32'(sda), 32'd0);
        PRESETn = 1'b0;
        #1;
        check("sda_in_rst", 32'(sda), 32'd1);
        check("busy_in_rst", 32'(busy), 32'd0);
        check("wr_addr_in_rst", 32'(wr_addr), 32'd0);
        check("wr_data_in_rst", 32'(wr_data), 32'd0);
        for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = '0;
        #20;
        PRESETn = 1'b1;
        m_sda = 1'b1; #T; m_scl = 1'b1; #(2*T);
        bus_start; send_addr(8'h79); recv_data(1'b0); bus_stop;
        bus_start; send_addr(8'h78); send_ptr(8'h01); send_data(8'h96); bus_stop;
        bus_start; send_addr(8'h78); send_ptr(8'h01);
        bus_start; send_addr(8'h79); recv_data(1'b0); bus_stop;

        // STOP after four data bits aborts the byte
        bus_start; send_addr(8'h78); send_ptr(8'h01);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop; #T;
        check("busy_after_abort", 32'(busy), 32'd0);
        bus_start; send_addr(8'h79); recv_data(1'b0); bus_stop;

        #T;
        check("wr_queue_empty", 32'(sb_wr.size()), 32'd0);
        check("addr_hit_cycles", 32'(hit_cycles), 32'(exp_hits));
        check("wr_strobe_cycles", 32'(wr_cycles), 32'(exp_wr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_target_model.md
# i2c_target_model

Synthesizable I2C target (slave) that sits directly downstream of the I2C-APB master on the shared `sda`/`scl` wires: it responds to its 7-bit address, ACKs, accepts register writes with an auto-incrementing pointer, and returns register contents on reads. It closes the loop on the bus so master transmit and receive paths can be checked end-to-end. Standard mode only; no clock stretching and no 10-bit addressing.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h3C, 7-bit I2C address this target answers to.
- `REG_DEPTH`, 8, number of 8-bit registers; power of two, 2..256.

Ports:
- `PCLK`  input  1  system clock; oversamples the bus.
- `PRESETn`  input  1  asynchronous, active-low reset.
- `scl`  input  1  I2C clock; never driven by this block.
- `sda`  inout  1  I2C data, open-drain: drives 1'b0 or 1'bz only.
- `busy`  output  1  high from an address-matched START until STOP, or until a repeated START with another address.
- `addr_hit`  output  1  one-`PCLK` pulse on address match.
- `wr_strobe`  output  1  one-`PCLK` pulse when a data byte is committed to a register.
- `wr_addr`  output  $clog2(REG_DEPTH)  register index of the committed byte.
- `wr_data`  output  8  committed byte value.

## Operation
- Input conditioning: `scl` and `sda` each pass through a 2-flop synchronizer and then a 1-flop delay for edge detection. All decisions use the synchronized values.
- START: synced `sda` falls while synced `scl` is high. STOP: synced `sda` rises while synced `scl` is high. Both are recognised in every state.
  - START, including repeated START, goes to ADDR.
  - STOP goes to IDLE and releases `sda`.
- Sampling and driving: bits are sampled on the synced `scl` rising edge. `sda` changes only after a synced `scl` falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits, MSB first.
  - If bits[7:1] equal `TARGET_ADDR`: pulse `addr_hit`, set `busy`, go to ADDR_ACK.
  - Otherwise go to IGNORE. IGNORE never drives `sda` and waits for START or STOP.
- ADDR_ACK: drive `sda` low for the 9th clock.
  - R/W=0: next state is PTR.
  - R/W=1: load the shift register from `regs[ptr]` and go to RDATA.
- PTR: the received byte's low $clog2(REG_DEPTH) bits load `ptr`; upper bits are ignored. ACK, then go to WDATA.
- WDATA: on the 8th bit, write `regs[ptr]`, pulse `wr_strobe` with `wr_addr=ptr` and `wr_data=byte`, increment `ptr`, then ACK.
  - `ptr` wraps from REG_DEPTH-1 to 0.
  - Bytes continue until STOP or START.
- RDATA: drive each bit (drive 0 for a 0 bit, z for a 1 bit); release `sda` for the 9th clock.
  - Master ACK (sampled `sda`=0): increment `ptr` with wrap, reload the shift register, stay in RDATA.
  - Master NACK: go to IGNORE until STOP or START.
- `ptr` persists across transactions. A read without a preceding pointer write starts at the last `ptr`.
- Reset, asynchronous at any point (including mid-byte):
  - state IDLE, `sda` released (z);
  - `busy`, `addr_hit`, `wr_strobe` = 0; `wr_addr` = 0; `wr_data` = 8'h00;
  - `ptr` = 0; all registers = 8'h00.

## Timing
- Detection latency: 3 `PCLK` from a pin edge to the internal edge or condition flag.
- Minimum bus phases: `scl` high and `scl` low each ≥ 6 `PCLK`. `sda` setup and hold around `scl` edges ≥ 4 `PCLK`.
- ACK and data drive:
  - `sda` changes within 4 `PCLK` of the `scl` pin falling.
  - `sda` is held until the next `scl` falling edge is detected, so it is held through the entire high phase.
- `wr_strobe` and `addr_hit` assert exactly 1 `PCLK`, on the cycle after the 8th-bit rising edge is detected.
- The register write is visible to a read pointer on the next `PCLK`.
- A START or STOP detected mid-byte aborts the byte: no write, no pointer change.

## Test plan
- Write 0x78 (addr 0x3C, W), ptr 0x02, data 0xA5 and 0x5A, STOP → ACK on all 4 bytes; `wr_strobe` pulses twice with (2, 0xA5) then (3, 0x5A); `busy` drops after STOP.
- Write ptr 0x07, data 0x11, 0x22 → writes land at index 7, then 0 (wrap); reading from ptr 0x07 with 2 bytes returns 0x11, 0x22.
- Address 0x52 (0x29, W) → no ACK (9th bit `sda`=1), `addr_hit` and `busy` stay 0, no `wr_strobe`, `sda` never driven.
- Write ptr 0x03 then repeated START, 0x79 (R), master ACK, ACK, NACK, STOP → returns regs[3..5]; `sda` released after the NACK.
- Assert `PRESETn` low mid-way through a data byte → `sda` is z immediately; a subsequent read of ptr 0 returns 0x00; a new transaction after release works normally.
- Glitch-free STOP inside WDATA after 4 bits → no write, state IDLE, the next START is accepted.
